// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the mips_32 fetch/load-store stages, the memory arbiter and unified memory.
// The slave modport is the arbiter's view; master is the core-plus-memory side.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ack;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_be;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_ack;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_done;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_done
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for mips_32: D-port has priority over I-port, one transaction at a time.
// Optional starvation guard for the I-port is enabled by defining MEM_ARB_STARVE_LIMIT_EN.
module mips_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_mem_arbiter_if.slave       bus,
    output logic                    arb_busy,
    output logic                    arb_owner
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              mem_req_q, mem_req_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              idle;
    logic              grant_i;
    logic              grant_d;

    assign idle = (state_q == S_IDLE);

`ifdef MEM_ARB_STARVE_LIMIT_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starved;

    assign starved = (starve_q >= CNT_W'(STARVE_LIMIT));

    // Counter only tracks D grants that actually overtook a waiting fetch; it saturates.
    always_comb begin
        grant_i  = idle && bus.if_req && (!bus.dm_req || starved);
        grant_d  = idle && bus.dm_req && !grant_i;
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d) begin
            if (!bus.if_req)  starve_d = '0;
            else if (!starved) starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    always_comb begin
        grant_d = idle && bus.dm_req;
        grant_i = idle && bus.if_req && !bus.dm_req;
    end
`endif

    always_comb begin
        // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        mem_req_d  = 1'b0;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    state_d   = S_ISSUE;
                    owner_d   = 1'b1;
                    we_d      = bus.dm_we;
                    addr_d    = bus.dm_addr;
                    wdata_d   = bus.dm_wdata;
                    be_d      = bus.dm_be;
                    mem_req_d = 1'b1;
                end else if (grant_i) begin
                    state_d   = S_ISSUE;
                    owner_d   = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = bus.if_addr;
                    wdata_d   = '0;
                    be_d      = '0;
                    mem_req_d = 1'b1;
                end
            end
            // A completion in the issue cycle skips WAIT; the ack is raised together with RESP.
            S_ISSUE, S_WAIT: begin
                if (bus.mem_done) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        dm_ack_d = 1'b1;
                        if (!we_q) dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            mem_req_q  <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            mem_req_q  <= mem_req_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign arb_busy      = !idle;
    assign arb_owner     = owner_q;
endmodule
